pipe_stage_buf: RTL and testbench

- Parametrised, elastic successor to the fixed IF/ID-style enable register.
- Carries NUM_FIELDS payload fields of DATA_WIDTH bits between two pipeline stages using a valid/ready handshake.
- Optional 2-entry skid buffer breaks the combinational ready path.
- Provides flush with bubble (NOP) injection and a saturating stall counter for performance debug.
- Instantiated between any two stages, e.g. IF/ID and ID/EX.

---
 rtl/pipe_stage_buf.sv | 188 ++++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic valid/ready pipeline stage register with skid buffer, flush and stall counter
//
// Purpose:
//   Carries NUM_FIELDS payload fields of DATA_WIDTH bits between two pipeline
//   stages. With SKID_EN = 1 a second (skid) entry lets up_ready_o come straight
//   from a register, so no combinational path runs from dn_ready_i to up_ready_o.
//   With SKID_EN = 0 the block is a single entry whose ready passes through.
//   While the output is invalid the NOP_FIELD field shows NOP_VALUE (a bubble)
//   and every other field shows zero.
//
// Ports:
//   clk_i        in   1                      clock, rising edge
//   rst_i        in   1                      synchronous reset, active-high
//   flush_i      in   1                      discard all held entries this cycle
//   up_valid_i   in   1                      upstream payload valid
//   up_ready_o   out  1                      block can accept payload
//   up_data_i    in   NUM_FIELDS*DATA_WIDTH  upstream payload
//   dn_valid_o   out  1                      downstream payload valid
//   dn_ready_i   in   1                      downstream accepts payload
//   dn_data_o    out  NUM_FIELDS*DATA_WIDTH  downstream payload (bubble when invalid)
//   occupancy_o  out  2                      entries held (0..2)
//   stall_cnt_o  out  CNT_WIDTH              saturating count of stalled-output cycles

module pipe_stage_buf #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_FIELDS = 2,
  parameter bit                    SKID_EN    = 1'b1,
  parameter int                    NOP_FIELD  = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = DATA_WIDTH'(32'h0000_0013),
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic                             up_valid_i,
  output logic                             up_ready_o,
  input  logic [NUM_FIELDS*DATA_WIDTH-1:0] up_data_i,
  output logic                             dn_valid_o,
  input  logic                             dn_ready_i,
  output logic [NUM_FIELDS*DATA_WIDTH-1:0] dn_data_o,
  output logic [1:0]                       occupancy_o,
  output logic [CNT_WIDTH-1:0]             stall_cnt_o
);

  localparam int PW = NUM_FIELDS * DATA_WIDTH;

  // Bubble shown downstream whenever nothing valid is held.
  localparam logic [PW-1:0] NOP_PAT = PW'(NOP_VALUE) << (NOP_FIELD * DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PW-1:0]         r_main;
  logic [PW-1:0]         r_skid;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;

  logic w_push;
  logic w_pop;
  logic w_load_main_up;
  logic w_load_main_skid;
  logic w_load_skid;
  logic w_stall;
  logic w_cnt_sat;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign dn_valid_o = (r_state == ST_FULL) || (r_state == ST_SKID);

  // The skid variant looks only at registered state; the single-entry variant
  // lets a draining downstream free the slot in the same cycle.
  generate
    if (SKID_EN) begin : g_ready_skid
      assign up_ready_o = (r_state != ST_SKID) && !rst_i;
    end else begin : g_ready_pass
      assign up_ready_o = (!dn_valid_o || dn_ready_i) && !rst_i;
    end
  endgenerate

  assign w_push = up_valid_i && up_ready_o;
  assign w_pop  = dn_valid_o && dn_ready_i;

  // ---------------------------------------------------------------------------
  // Next-state and register-load decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_up   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;

    // Flush outranks every handshake: a push in the same cycle is dropped
    // because no load strobe is raised.
    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_state_nxt    = ST_FULL;
            w_load_main_up = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_push && w_pop) begin
            w_load_main_up = 1'b1;
          end else if (w_push) begin
            // Only reachable with the skid entry present; the single-entry
            // ready forbids a push into a full, stalled stage.
            if (SKID_EN) begin
              w_state_nxt = ST_SKID;
              w_load_skid = 1'b1;
            end
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (w_pop) begin
            w_state_nxt      = ST_FULL;
            w_load_main_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Data registers only move on real transfers, never on idle cycles.
      if (w_load_main_up) begin
        r_main <= up_data_i;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= up_data_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stall counter: counts cycles where valid data waits on downstream.
  // Flush does not clear it so a debug read survives pipeline redirects.
  // ---------------------------------------------------------------------------
  assign w_stall   = dn_valid_o && !dn_ready_i;
  assign w_cnt_sat = (r_stall_cnt == {CNT_WIDTH{1'b1}});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !w_cnt_sat) begin
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dn_data_o   = dn_valid_o ? r_main : NOP_PAT;
  assign stall_cnt_o = r_stall_cnt;

  always_comb begin
    occupancy_o = 2'd0;
    case (r_state)
      ST_FULL: occupancy_o = 2'd1;
      ST_SKID: occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - self-checking bench for pipe_stage_buf (skid and single-entry variants)

module tb_pipe_stage_buf;

  localparam int DW = 32;
  localparam int NF = 2;
  localparam int PW = DW * NF;
  localparam int CNT_MAX = 3;
  localparam logic [PW-1:0] NOP_PAT = {32'h0000_0013, 32'h0000_0000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          flush;
  logic          up_valid;
  logic [PW-1:0] up_data;
  logic          dn_ready;

  logic [1:0]          up_ready;
  logic [1:0]          dn_valid;
  logic [1:0][PW-1:0]  dn_data;
  logic [1:0][1:0]     occ;
  logic [1:0][1:0]     stall;

  int checks = 0;
  int errors = 0;

  // Reference model: instance 0 = skid (capacity 2), instance 1 = single entry.
  // Each holds an ordered list of entries me[i][0..mn-1] plus a stall count.
  logic [PW-1:0] me [2][2];
  int            mn [2];
  int            mc [2];

  pipe_stage_buf #(.SKID_EN(1'b1), .CNT_WIDTH(2)) u_skid (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .up_valid_i  (up_valid),
    .up_ready_o  (up_ready[0]),
    .up_data_i   (up_data),
    .dn_valid_o  (dn_valid[0]),
    .dn_ready_i  (dn_ready),
    .dn_data_o   (dn_data[0]),
    .occupancy_o (occ[0]),
    .stall_cnt_o (stall[0])
  );

  pipe_stage_buf #(.SKID_EN(1'b0), .CNT_WIDTH(2)) u_pass (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .up_valid_i  (up_valid),
    .up_ready_o  (up_ready[1]),
    .up_data_i   (up_data),
    .dn_valid_o  (dn_valid[1]),
    .dn_ready_i  (dn_ready),
    .dn_data_o   (dn_data[1]),
    .occupancy_o (occ[1]),
    .stall_cnt_o (stall[1])
  );

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Drive one cycle of inputs just after a falling edge, check every output
  // against the model, advance the model by the rules of the next rising edge,
  // then move to the following falling edge.
  task automatic cyc(input logic r, input logic f, input logic uv,
                     input logic [PW-1:0] d, input logic dr);
    logic exp_rdy;
    logic exp_vld;
    logic push;
    rst      = r;
    flush    = f;
    up_valid = uv;
    up_data  = d;
    dn_ready = dr;
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_vld = (mn[i] > 0);
      if (i == 0) exp_rdy = !r && (mn[i] < 2);
      else        exp_rdy = !r && ((mn[i] == 0) || dr);
      chk($sformatf("up_ready[%0d]", i), PW'(up_ready[i]), PW'(exp_rdy));
      chk($sformatf("dn_valid[%0d]", i), PW'(dn_valid[i]), PW'(exp_vld));
      chk($sformatf("dn_data[%0d]", i), dn_data[i], exp_vld ? me[i][0] : NOP_PAT);
      chk($sformatf("occupancy[%0d]", i), PW'(occ[i]), PW'(mn[i]));
      chk($sformatf("stall_cnt[%0d]", i), PW'(stall[i]), PW'(mc[i]));

      if (r) begin
        mn[i] = 0;
        mc[i] = 0;
      end else begin
        if (exp_vld && !dr && mc[i] < CNT_MAX) mc[i]++;
        push = uv && exp_rdy;
        if (f) begin
          mn[i] = 0;
        end else begin
          if (exp_vld && dr) begin
            me[i][0] = me[i][1];
            mn[i]--;
          end
          if (push) begin
            me[i][mn[i]] = d;
            mn[i]++;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [PW-1:0] w0;
    logic [PW-1:0] w1;
    logic [PW-1:0] w2;
    logic [PW-1:0] rd;

    w0 = {32'h0000_000A, 32'h0000_0004};
    w1 = {32'h0000_000B, 32'h0000_0008};
    w2 = {32'h0000_00C0, 32'h0000_000C};

    rst = 1'b1; flush = 1'b0; up_valid = 1'b0; up_data = '0; dn_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      mn[i] = 0; mc[i] = 0; me[i][0] = '0; me[i][1] = '0;
    end

    // Reset held, then idle
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("idle_nop_pattern", dn_data[0], NOP_PAT);
    chk("idle_ready", PW'(up_ready[0]), PW'(1'b1));

    // Back-to-back streaming
    cyc(1'b0, 1'b0, 1'b1, w0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, w1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, w2, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Backpressure into the skid entry, then drain in order
    cyc(1'b0, 1'b0, 1'b1, w0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, w1, 1'b0);
    chk("bp_occupancy_2", PW'(occ[0]), PW'(2'd2));
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Flush while in SKID with upstream offering a word
    cyc(1'b0, 1'b0, 1'b1, w0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, w1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, w2, 1'b0);
    chk("flush_nop", dn_data[0], NOP_PAT);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Stall counter saturation, survives flush, cleared by reset
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, w0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("stall_saturated", PW'(stall[0]), PW'(2'd3));
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("stall_after_flush", PW'(stall[0]), PW'(2'd3));
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("stall_after_reset", PW'(stall[0]), PW'(2'd0));

    // Single-entry variant: blocked, then same-cycle ready and replace
    cyc(1'b0, 1'b0, 1'b1, w0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, w1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, w2, 1'b1);
    chk("pass_replaced", dn_data[1], w2);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Reset while in SKID
    cyc(1'b0, 1'b0, 1'b1, w0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, w1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("reset_in_skid_occ", PW'(occ[0]), PW'(2'd0));
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      rd = {$urandom, $urandom};
      cyc(($urandom_range(0, 63) == 0),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 3) != 0),
          rd,
          ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
